// File: rtl/ext_sram_ctrl.sv
// rtl/ext_sram_ctrl.sv - core bus strobes to timed 16-bit async SRAM cycles
// Define SRAM_POSTED_WRITE_EN to post writes in the background without WAIT.
module ext_sram_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_BITS   = 15
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [15:0]          ADDR,
  input  logic [15:0]          DOUT,
  input  logic                 RDN,
  input  logic                 WRN0,
  input  logic                 WRN1,
  output logic [15:0]          DIN,
  output logic                 WAIT,
  output logic                 BUS_ERR,
  output logic [ADDR_BITS-1:0] SRAM_A,
  output logic [15:0]          SRAM_DQ_O,
  input  logic [15:0]          SRAM_DQ_I,
  output logic                 SRAM_DQ_OE,
  output logic                 SRAM_CEN,
  output logic                 SRAM_OEN,
  output logic                 SRAM_WEN,
  output logic                 SRAM_LBN,
  output logic                 SRAM_UBN
);

`ifdef SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           state;
  logic [3:0]           cnt;
  logic                 rdn_q, rdn_qq, wrn0_q, wrn1_q, wr_qq;
  logic                 wr_q, rd_fall, wr_fall, strobe_start, start_wr, start_both;
  logic                 cur_wr, lbn_r, ubn_r;
  logic [ADDR_BITS-1:0] a_r;
  logic [15:0]          d_r;
  logic                 req_valid, req_wr, req_lbn, req_ubn;
  logic [ADDR_BITS-1:0] req_a;
  logic [15:0]          req_d;
  logic                 launch_req, queue_req, load, active;
  logic                 ld_wr, ld_lbn, ld_ubn;
  logic [ADDR_BITS-1:0] ld_a;
  logic [15:0]          ld_d;
  logic                 unused_addr;

  // Edges are taken between two registered copies so the core strobes are sampled only once.
  assign wr_q         = wrn0_q & wrn1_q;
  assign rd_fall      = rdn_qq & ~rdn_q;
  assign wr_fall      = wr_qq & ~wr_q;
  assign strobe_start = rd_fall | wr_fall;
  assign start_wr     = ~wr_q;
  assign start_both   = ~wr_q & ~rdn_q;
  assign launch_req   = POSTED && req_valid && (state == S_IDLE || state == S_DONE);
  assign queue_req    = POSTED && strobe_start && !req_valid && (state != S_IDLE);
  assign load         = launch_req || (state == S_IDLE && strobe_start);
  assign active       = (state == S_SETUP) || (state == S_ACCESS) || (state == S_HOLD);
  assign unused_addr  = ADDR[0];

  always_comb begin
    ld_wr  = start_wr;
    ld_a   = ADDR[ADDR_BITS:1];
    ld_d   = DOUT;
    ld_lbn = start_wr ? wrn0_q : 1'b0;
    ld_ubn = start_wr ? wrn1_q : 1'b0;
    if (launch_req) begin
      ld_wr  = req_wr;
      ld_a   = req_a;
      ld_d   = req_d;
      ld_lbn = req_lbn;
      ld_ubn = req_ubn;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rdn_q  <= 1'b1;
      rdn_qq <= 1'b1;
      wrn0_q <= 1'b1;
      wrn1_q <= 1'b1;
      wr_qq  <= 1'b1;
    end else begin
      rdn_q  <= RDN;
      rdn_qq <= rdn_q;
      wrn0_q <= WRN0;
      wrn1_q <= WRN1;
      wr_qq  <= wr_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cur_wr  <= 1'b0;
      a_r     <= '0;
      d_r     <= '0;
      lbn_r   <= 1'b1;
      ubn_r   <= 1'b1;
      DIN     <= '0;
      BUS_ERR <= 1'b0;
    end else begin
      BUS_ERR <= strobe_start && start_both && (state == S_IDLE || queue_req);
      if (load) begin
        cur_wr <= ld_wr;
        a_r    <= ld_a;
        d_r    <= ld_d;
        lbn_r  <= ld_lbn;
        ubn_r  <= ld_ubn;
      end
      case (state)
        S_IDLE:   if (load) state <= S_SETUP;
        S_SETUP: begin
          state <= S_ACCESS;
          cnt   <= 4'(WAIT_STATES);
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state <= cur_wr ? S_HOLD : S_DONE;
            if (!cur_wr) DIN <= SRAM_DQ_I;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD:   state <= S_DONE;
        S_DONE:   state <= load ? S_SETUP : S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Single-entry holding slot for a request that arrives while a posted write is running.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      req_valid <= 1'b0;
      req_wr    <= 1'b0;
      req_a     <= '0;
      req_d     <= '0;
      req_lbn   <= 1'b1;
      req_ubn   <= 1'b1;
    end else if (queue_req) begin
      req_valid <= 1'b1;
      req_wr    <= start_wr;
      req_a     <= ADDR[ADDR_BITS:1];
      req_d     <= DOUT;
      req_lbn   <= start_wr ? wrn0_q : 1'b0;
      req_ubn   <= start_wr ? wrn1_q : 1'b0;
    end else if (launch_req) begin
      req_valid <= 1'b0;
    end
  end

  always_comb begin
    WAIT = (state == S_IDLE && strobe_start) || active;
    if (POSTED)
      WAIT = (strobe_start && (!start_wr || state != S_IDLE)) || req_valid || (active && !cur_wr);
  end

  assign SRAM_A     = a_r;
  assign SRAM_DQ_O  = d_r;
  assign SRAM_CEN   = ~active;
  assign SRAM_OEN   = ~(state == S_ACCESS && !cur_wr);
  assign SRAM_WEN   = ~(state == S_ACCESS && cur_wr);
  assign SRAM_DQ_OE = active && cur_wr;
  assign SRAM_LBN   = active ? lbn_r : 1'b1;
  assign SRAM_UBN   = active ? ubn_r : 1'b1;

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// tb/tb_ext_sram_ctrl.sv - directed bench for ext_sram_ctrl at WAIT_STATES 1 and 0
module tb_ext_sram_ctrl;
  logic        CLK = 1'b0;
  logic        RESETN;
  logic [15:0] ADDR, DOUT, SRAM_DQ_I;
  logic        RDN, WRN0, WRN1;
  logic [15:0] din, din0, dq_o, dq_o0;
  logic [14:0] a1, a0;
  logic        wait1, wait0, err1, err0, oe1, oe0, cen1, cen0, oen1, oen0;
  logic        wen1, wen0, lbn1, lbn0, ubn1, ubn0;

  int          checks = 0;
  int          failures = 0;
  int          t0, wait_cnt, wen_cnt, oen_cnt, oen0_cnt, err_cnt, din_t, din0_t;
  logic [14:0] a_seen, a0_seen;
  logic [15:0] dq_seen;
  logic [1:0]  lanes_seen;

  always #5 CLK = ~CLK;

  ext_sram_ctrl #(.WAIT_STATES(1), .ADDR_BITS(15)) dut (
    .CLK(CLK), .RESETN(RESETN), .ADDR(ADDR), .DOUT(DOUT), .RDN(RDN), .WRN0(WRN0), .WRN1(WRN1),
    .DIN(din), .WAIT(wait1), .BUS_ERR(err1), .SRAM_A(a1), .SRAM_DQ_O(dq_o), .SRAM_DQ_I(SRAM_DQ_I),
    .SRAM_DQ_OE(oe1), .SRAM_CEN(cen1), .SRAM_OEN(oen1), .SRAM_WEN(wen1), .SRAM_LBN(lbn1), .SRAM_UBN(ubn1)
  );

  ext_sram_ctrl #(.WAIT_STATES(0), .ADDR_BITS(15)) dut0 (
    .CLK(CLK), .RESETN(RESETN), .ADDR(ADDR), .DOUT(DOUT), .RDN(RDN), .WRN0(WRN0), .WRN1(WRN1),
    .DIN(din0), .WAIT(wait0), .BUS_ERR(err0), .SRAM_A(a0), .SRAM_DQ_O(dq_o0), .SRAM_DQ_I(SRAM_DQ_I),
    .SRAM_DQ_OE(oe0), .SRAM_CEN(cen0), .SRAM_OEN(oen0), .SRAM_WEN(wen0), .SRAM_LBN(lbn0), .SRAM_UBN(ubn0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One strobe cycle: strobes released mid-cycle, 12 samples on the falling edge.
  task automatic do_op(input logic rd, input logic w0, input logic w1,
                       input logic [15:0] a, input logic [15:0] d, input logic [15:0] q);
    logic [15:0] din_before, din0_before;
    ADDR = a; DOUT = d; SRAM_DQ_I = q;
    din_before = din; din0_before = din0;
    t0 = -1; wait_cnt = 0; wen_cnt = 0; oen_cnt = 0; oen0_cnt = 0; err_cnt = 0;
    din_t = -1; din0_t = -1;
    a_seen = 15'h7fff; a0_seen = 15'h7fff; dq_seen = 16'hxxxx; lanes_seen = 2'b11;
    @(negedge CLK);
    RDN = rd; WRN0 = w0; WRN1 = w1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (wait1) begin
        if (t0 < 0) t0 = i;
        wait_cnt++;
      end
      if (!wen1) wen_cnt++;
      if (!oen1) oen_cnt++;
      if (!oen0) oen0_cnt++;
      if (err1) err_cnt++;
      if (!cen1) begin
        a_seen = a1; dq_seen = dq_o; lanes_seen = {lbn1, ubn1};
      end
      if (!cen0) a0_seen = a0;
      if (din_t < 0 && din !== din_before) din_t = i - t0;
      if (din0_t < 0 && din0 !== din0_before) din0_t = i - t0;
      if (i == 2) begin
        RDN = 1'b1; WRN0 = 1'b1; WRN1 = 1'b1;
      end
    end
  endtask

  initial begin
    RESETN = 1'b0; RDN = 1'b1; WRN0 = 1'b1; WRN1 = 1'b1;
    ADDR = '0; DOUT = '0; SRAM_DQ_I = '0;
    repeat (3) @(negedge CLK);
    check("rst_ctl", {cen1, oen1, wen1, lbn1, ubn1, oe1, wait1, err1}, 8'b11111000);
    check("rst_data", {din, dq_o, 1'b0, a1}, 48'h0);
    RESETN = 1'b1;
    repeat (2) @(negedge CLK);

    do_op(1'b1, 1'b0, 1'b0, 16'hfaaf, 16'h0056, 16'h0000);
    check("wr_start", t0, 0);
    check("wr_addr", a_seen, 15'h7d57);
    check("wr_data", dq_seen, 16'h0056);
    check("wr_lanes", lanes_seen, 2'b00);
    check("wr_wen", wen_cnt, 2);
    check("wr_wait", wait_cnt, 5);
    check("wr_oen", oen_cnt, 0);
    check("wr_din", din, 16'h0000);

    do_op(1'b0, 1'b1, 1'b1, 16'h0056, 16'h0000, 16'h3456);
    check("rd_addr", a_seen, 15'h002b);
    check("rd_oen", oen_cnt, 2);
    check("rd_lat", din_t, 4);
    check("rd_din", din, 16'h3456);
    check("rd_wait", wait_cnt, 4);
    check("rd_wen", wen_cnt, 0);

    do_op(1'b1, 1'b0, 1'b1, 16'h0058, 16'h1234, 16'h0000);
    check("lo_addr", a_seen, 15'h002c);
    check("lo_lanes", lanes_seen, 2'b01);
    check("lo_din_held", din, 16'h3456);

    do_op(1'b1, 1'b1, 1'b0, 16'h0058, 16'h1234, 16'h0000);
    check("hi_lanes", lanes_seen, 2'b10);
    check("hi_wen", wen_cnt, 2);

    do_op(1'b0, 1'b0, 1'b1, 16'h0101, 16'hbeef, 16'h9999);
    check("err_pulse", err_cnt, 1);
    check("err_lanes", lanes_seen, 2'b01);
    check("err_oen", oen_cnt, 0);
    check("err_wen", wen_cnt, 2);
    check("err_addr", a_seen, 15'h0080);
    check("err_din", din, 16'h3456);

    ADDR = 16'h0200; DOUT = 16'h7777;
    @(negedge CLK);
    WRN0 = 1'b0; WRN1 = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_in_access", {wen1, oe1}, 2'b01);
    RESETN = 1'b0;
    #1;
    check("rst_async", {cen1, wen1, oe1, wait1, oen1}, 5'b11001);
    check("rst_async_din", din, 16'h0000);
    WRN0 = 1'b1; WRN1 = 1'b1;
    @(negedge CLK);
    RESETN = 1'b1;
    repeat (2) @(negedge CLK);

    do_op(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'ha5c3);
    check("post_rst_addr", a_seen, 15'h0000);
    check("post_rst_lat", din_t, 4);
    check("post_rst_din", din, 16'ha5c3);

    do_op(1'b0, 1'b1, 1'b1, 16'h005a, 16'h0000, 16'h5678);
    check("ws0_addr", a0_seen, 15'h002d);
    check("ws0_oen", oen0_cnt, 1);
    check("ws0_lat", din0_t, 3);
    check("ws0_din", din0, 16'h5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
